pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC, the IF/ID, ID/EX and EX/MEM pipeline registers, and the MEM/WB register.
- It detects three conditions:
  - load-use hazards (EX stage against ID stage);
  - taken branches resolved at the MEM stage;
  - multi-cycle data-memory accesses (req/ready handshake).
- It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MEM-stage branch redirect, multi-cycle dmem.
// Latency: control outputs are combinational (same-cycle response); state and counters update on CLK.
// Backpressure: an outstanding dmem access freezes the whole pipe; a timeout aborts it with a WB bubble.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesRt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_regWriteAddress,
  input  logic             mem_branchTaken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             stat_clr,
  output logic             PCWrite,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_write,
  output logic             EXMEM_flush,
  output logic             MEMWB_write,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LUSE     = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_nxt;
  logic       load_use;
  logic       mem_busy;
  logic       run_eval;
  logic       busy_eval;
  logic       lu_eval;
  logic       stall_inc;
  logic       flush_inc;
  logic       err_set;

  // $0 is hardwired, so a load targeting it can never create a dependency
  assign load_use = ex_memRead && (ex_regWriteAddress != 5'd0) &&
                    ((ex_regWriteAddress == id_rs) ||
                     (id_usesRt && (ex_regWriteAddress == id_rt)));
  assign mem_busy = dmem_req && !dmem_ready;
  assign state    = cur_state;

  // Select the rule set: RUN rules apply in RUN, LUSE (no load-use re-check) and on the MEM_WAIT ready cycle
  always_comb begin
    run_eval  = 1'b0;
    busy_eval = 1'b0;
    lu_eval   = 1'b0;
    case (cur_state)
      RUN: begin
        run_eval  = 1'b1;
        busy_eval = mem_busy;
        lu_eval   = 1'b1;
      end
      LUSE: begin
        run_eval  = 1'b1;
        busy_eval = mem_busy;
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          run_eval = 1'b1;
          lu_eval  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pipeline controls, next state and counter events; reset forces bubbles everywhere
  always_comb begin
    PCWrite     = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_write = 1'b1;
    EXMEM_flush = 1'b0;
    MEMWB_write = 1'b1;
    nxt_state   = RUN;
    tmo_nxt     = tmo_cnt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    err_set     = 1'b0;

    if (run_eval) begin
      if (busy_eval) begin
        PCWrite     = 1'b0;
        IFID_write  = 1'b0;
        EXMEM_write = 1'b0;
        MEMWB_write = 1'b0;
        nxt_state   = MEM_WAIT;
        tmo_nxt     = 8'd1;
      end else if (mem_branchTaken) begin
        IFID_flush  = 1'b1;
        IDEX_flush  = 1'b1;
        EXMEM_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (lu_eval && load_use) begin
        PCWrite     = 1'b0;
        IFID_write  = 1'b0;
        IDEX_flush  = 1'b1;
        stall_inc   = 1'b1;
        nxt_state   = LUSE;
      end
    end else if (cur_state == MEM_WAIT) begin
      PCWrite     = 1'b0;
      IFID_write  = 1'b0;
      EXMEM_write = 1'b0;
      MEMWB_write = 1'b0;
      stall_inc   = 1'b1;
      if (tmo_cnt >= TMO_LIM) begin
        // give up on the access: a bubble goes down to WB and the pipe restarts
        EXMEM_flush = 1'b1;
        MEMWB_write = 1'b1;
        err_set     = 1'b1;
        nxt_state   = RUN;
      end else begin
        tmo_nxt   = tmo_cnt + 8'd1;
        nxt_state = MEM_WAIT;
      end
    end

    if (!Reset) begin
      PCWrite     = 1'b0;
      IFID_write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_write = 1'b0;
      EXMEM_flush = 1'b1;
      MEMWB_write = 1'b0;
    end
  end

  // FSM state and memory-wait timeout counter
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur_state <= RUN;
      tmo_cnt   <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      tmo_cnt   <= tmo_nxt;
    end
  end

  // Saturating performance counters and sticky timeout flag; clear beats any same-cycle event
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (err_set) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances, default parameters (a) and MEM_TIMEOUT=4/CNT_W=4 (b).
// Inputs change on the falling edge; combinational controls are sampled 1 ns later, registers after the next rise.
// Control vectors are packed {PCWrite, IFID_write, IFID_flush, IDEX_flush, EXMEM_write, EXMEM_flush, MEMWB_write}.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_DEF = 7'b1100101;
  localparam logic [6:0] C_RST = 7'b0011010;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_BR  = 7'b1111111;
  localparam logic [6:0] C_LU  = 7'b0001101;
  localparam logic [6:0] C_ABT = 7'b0000011;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [4:0] id_rs, id_rt, ex_regWriteAddress;
  logic       id_usesRt, ex_memRead, mem_branchTaken, dmem_req, dmem_ready, stat_clr;

  logic        a_pcw, a_ifw, a_iff, a_idf, a_exw, a_exf, a_mww, a_err;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_flush;
  logic        b_pcw, b_ifw, b_iff, b_idf, b_exw, b_exf, b_mww, b_err;
  logic [1:0]  b_state;
  logic [3:0]  b_stall, b_flush;
  logic [6:0]  a_ctrl, b_ctrl;

  int checks = 0;
  int passes = 0;

  assign a_ctrl = {a_pcw, a_ifw, a_iff, a_idf, a_exw, a_exf, a_mww};
  assign b_ctrl = {b_pcw, b_ifw, b_iff, b_idf, b_exw, b_exf, b_mww};

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut_a (
    .CLK(CLK), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
    .ex_memRead(ex_memRead), .ex_regWriteAddress(ex_regWriteAddress),
    .mem_branchTaken(mem_branchTaken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stat_clr(stat_clr), .PCWrite(a_pcw), .IFID_write(a_ifw), .IFID_flush(a_iff),
    .IDEX_flush(a_idf), .EXMEM_write(a_exw), .EXMEM_flush(a_exf), .MEMWB_write(a_mww),
    .state(a_state), .stall_cnt(a_stall), .flush_cnt(a_flush), .mem_err(a_err)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .CLK(CLK), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
    .ex_memRead(ex_memRead), .ex_regWriteAddress(ex_regWriteAddress),
    .mem_branchTaken(mem_branchTaken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stat_clr(stat_clr), .PCWrite(b_pcw), .IFID_write(b_ifw), .IFID_flush(b_iff),
    .IDEX_flush(b_idf), .EXMEM_write(b_exw), .EXMEM_flush(b_exf), .MEMWB_write(b_mww),
    .state(b_state), .stall_cnt(b_stall), .flush_cnt(b_flush), .mem_err(b_err)
  );

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_usesRt = 1'b0; ex_memRead = 1'b0;
    ex_regWriteAddress = 5'd0; mem_branchTaken = 1'b0; dmem_req = 1'b0;
    dmem_ready = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
    ex_memRead = 1'b1; ex_regWriteAddress = rd; id_rs = rs; id_rt = rt; id_usesRt = uses_rt;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle();
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    idle();
    Reset = 1'b0;
    #1;
    checks++; if (a_ctrl !== C_RST) $display("FAIL reset_ctrl got %b exp %b", a_ctrl, C_RST); else passes++;
    repeat (3) @(negedge CLK);
    checks++; if (a_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", a_state); else passes++;
    Reset = 1'b1;
    @(negedge CLK);
    #1;
    checks++; if (a_ctrl !== C_DEF) $display("FAIL release_ctrl got %b exp %b", a_ctrl, C_DEF); else passes++;
    checks++; if ({a_state, a_stall, a_flush, a_err} !== 35'd0)
      $display("FAIL release_regs got state=%0d stall=%0d flush=%0d err=%0b exp all 0", a_state, a_stall, a_flush, a_err);
    else passes++;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge CLK);
    set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    checks++; if (a_ctrl !== C_LU) $display("FAIL lu_rs_ctrl got %b exp %b", a_ctrl, C_LU); else passes++;
    @(negedge CLK);
    #1;
    // hazard inputs still present in LUSE: no re-check, defaults expected
    checks++; if (a_state !== 2'd1) $display("FAIL lu_state got %0d exp 1", a_state); else passes++;
    checks++; if (a_ctrl !== C_DEF) $display("FAIL luse_ctrl got %b exp %b", a_ctrl, C_DEF); else passes++;
    idle();
    @(negedge CLK);
    checks++; if (a_state !== 2'd0) $display("FAIL lu_return got %0d exp 0", a_state); else passes++;
    checks++; if (a_stall !== 16'd1) $display("FAIL lu_stall got %0d exp 1", a_stall); else passes++;
    // rt match with usesRt set stalls
    set_lu(5'd7, 5'd3, 5'd7, 1'b1);
    #1;
    checks++; if (a_ctrl !== C_LU) $display("FAIL lu_rt_ctrl got %b exp %b", a_ctrl, C_LU); else passes++;
    @(negedge CLK);
    idle();
    @(negedge CLK);
    // rt match but rt not read: no stall
    set_lu(5'd7, 5'd3, 5'd7, 1'b0);
    #1;
    checks++; if (a_ctrl !== C_DEF) $display("FAIL lu_rt_unused got %b exp %b", a_ctrl, C_DEF); else passes++;
    // $0 never stalls
    set_lu(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++; if (a_ctrl !== C_DEF) $display("FAIL lu_r0_ctrl got %b exp %b", a_ctrl, C_DEF); else passes++;
    @(negedge CLK);
    idle();
    checks++; if (a_state !== 2'd0 || a_stall !== 16'd2)
      $display("FAIL lu_r0_regs got state=%0d stall=%0d exp state=0 stall=2", a_state, a_stall);
    else passes++;
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge CLK);
    set_lu(5'd9, 5'd9, 5'd0, 1'b0);
    mem_branchTaken = 1'b1;
    #1;
    checks++; if (a_ctrl !== C_BR) $display("FAIL br_ctrl got %b exp %b", a_ctrl, C_BR); else passes++;
    @(negedge CLK);
    idle();
    checks++; if (a_state !== 2'd0 || a_flush !== 16'd1 || a_stall !== 16'd0)
      $display("FAIL br_regs got state=%0d flush=%0d stall=%0d exp 0/1/0", a_state, a_flush, a_stall);
    else passes++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    @(negedge CLK);
    dmem_req = 1'b1;
    #1;
    checks++; if (a_ctrl !== C_FRZ || a_state !== 2'd0)
      $display("FAIL mw_enter got ctrl=%b state=%0d exp %b/0", a_ctrl, a_state, C_FRZ);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      checks++; if (a_ctrl !== C_FRZ || a_state !== 2'd2)
        $display("FAIL mw_freeze%0d got ctrl=%b state=%0d exp %b/2", i, a_ctrl, a_state, C_FRZ);
      else passes++;
    end
    @(negedge CLK);
    dmem_ready = 1'b1;
    #1;
    checks++; if (a_ctrl !== C_DEF || a_state !== 2'd2)
      $display("FAIL mw_ready got ctrl=%b state=%0d exp %b/2", a_ctrl, a_state, C_DEF);
    else passes++;
    @(negedge CLK);
    idle();
    checks++; if (a_state !== 2'd0 || a_stall !== 16'd4 || a_err !== 1'b0)
      $display("FAIL mw_done got state=%0d stall=%0d err=%0b exp 0/4/0", a_state, a_stall, a_err);
    else passes++;
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge CLK);
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      checks++; if (b_ctrl !== C_FRZ || b_state !== 2'd2)
        $display("FAIL to_wait%0d got ctrl=%b state=%0d exp %b/2", i, b_ctrl, b_state, C_FRZ);
      else passes++;
    end
    @(negedge CLK);
    #1;
    checks++; if (b_ctrl !== C_ABT || b_err !== 1'b0)
      $display("FAIL to_abort got ctrl=%b err=%0b exp %b/0", b_ctrl, b_err, C_ABT);
    else passes++;
    @(negedge CLK);
    idle();
    checks++; if (b_state !== 2'd0 || b_err !== 1'b1)
      $display("FAIL to_after got state=%0d err=%0b exp 0/1", b_state, b_err);
    else passes++;
    @(negedge CLK);
    checks++; if (b_err !== 1'b1) $display("FAIL to_sticky got %0b exp 1", b_err); else passes++;
    stat_clr = 1'b1;
    @(negedge CLK);
    stat_clr = 1'b0;
    checks++; if (b_err !== 1'b0) $display("FAIL to_clear got %0b exp 0", b_err); else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      set_lu(5'd4, 5'd4, 5'd0, 1'b0);
      @(negedge CLK);
      idle();
    end
    @(negedge CLK);
    checks++; if (b_stall !== 4'd15) $display("FAIL sat_b got %0d exp 15", b_stall); else passes++;
    checks++; if (a_stall !== 16'd20) $display("FAIL cnt_a got %0d exp 20", a_stall); else passes++;
    set_lu(5'd4, 5'd4, 5'd0, 1'b0);
    stat_clr = 1'b1;
    @(negedge CLK);
    idle();
    checks++; if (b_stall !== 4'd0 || b_state !== 2'd1)
      $display("FAIL clr_wins got stall=%0d state=%0d exp 0/1", b_stall, b_state);
    else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge CLK);
    dmem_req = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (a_state !== 2'd0 || a_ctrl !== C_RST)
      $display("FAIL async_rst got state=%0d ctrl=%b exp 0/%b", a_state, a_ctrl, C_RST);
    else passes++;
    idle();
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
